rr_bus_mux: RTL and testbench

//  Parametrised N-channel registered bus multiplexer for the LC-3 datapath, replacing fixed-width

---
 rtl/rr_bus_mux.sv | 136 +++++++++++++
 tb/tb_rr_bus_mux.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_mux
// Purpose  : N-channel round-robin arbitrated bus mux with one output register.
//            Optional lock feature: define RR_BUS_MUX_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_mux #(
  parameter  int N_CH  = 3,
  parameter  int WIDTH = 16,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
`ifdef RR_BUS_MUX_LOCK_EN
  ,
  input  logic                  lock
`endif
);

  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [N_CH-1:0]  req;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] gnt_idx;
  logic             found;
  logic             load;
  logic             xfer;

`ifdef RR_BUS_MUX_LOCK_EN
  logic             locked_q, locked_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [N_CH-1:0]  lock_mask;

  // While locked, only the owning channel is allowed to compete.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_ch_q] = 1'b1;
    req                  = locked_q ? (in_valid & lock_mask) : in_valid;
  end
`else
  assign req = in_valid;
`endif

  // First requester after the last winner, wrapping around.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = SEL_W'((int'(rr_ptr_q) + k) % N_CH);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign load = ~out_valid_q | out_ready;
  assign xfer = found & load & Reset_n;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      rr_ptr_d    = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef RR_BUS_MUX_LOCK_EN
  always_comb begin
    locked_d  = locked_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      locked_d  = lock;
      lock_ch_d = gnt_idx;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_mux
// Purpose  : Scoreboard bench for rr_bus_mux (3x16 and 8x32 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_mux;

  logic        Clk;
  logic        Reset_n;
  logic [2:0]  in_valid;
  logic [47:0] in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [7:0]   in_valid8;
  logic [255:0] in_data8;
  logic [7:0]   in_ready8;
  logic         out_valid8;
  logic [31:0]  out_data8;
  logic [2:0]   out_sel8;
  logic         out_ready8;
`ifdef RR_BUS_MUX_LOCK_EN
  logic         lock;
  logic         lock8;
`endif

  typedef struct {
    int unsigned sel;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [15:0] d3 [3] = '{16'hA000, 16'hB111, 16'hC222};

  rr_bus_mux #(.N_CH(3), .WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
`ifdef RR_BUS_MUX_LOCK_EN
    , .lock(lock)
`endif
  );

  rr_bus_mux #(.N_CH(8), .WIDTH(32)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
    .out_sel(out_sel8), .out_ready(out_ready8)
`ifdef RR_BUS_MUX_LOCK_EN
    , .lock(lock8)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic test_reset();
    Reset_n    = 1'b0;
    in_valid   = 3'b111;
    in_data    = {d3[2], d3[1], d3[0]};
    out_ready  = 1'b1;
    in_valid8  = '0;
    in_data8   = '0;
    out_ready8 = 1'b1;
`ifdef RR_BUS_MUX_LOCK_EN
    lock  = 1'b0;
    lock8 = 1'b0;
`endif
    @(posedge Clk); #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 2'd0) begin
      $display("FAIL reset_out: got v=%b data=%h sel=%0d expected v=0 data=0000 sel=0",
               out_valid, out_data, out_sel);
    end else n_pass++;
    n_total++;
    if (in_ready !== 3'b000) begin
      $display("FAIL reset_in_ready: got %b expected 000", in_ready);
    end else n_pass++;
    n_total++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 8'h00) begin
      $display("FAIL reset_dut8: got v=%b rdy=%h expected v=0 rdy=00", out_valid8, in_ready8);
    end else n_pass++;
  endtask

  task automatic test_round_robin();
    int g;
    Reset_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      n_total++;
      if (in_ready !== (3'b001 << g)) begin
        $display("FAIL rr_ready%0d: got %b expected %b", k, in_ready, 3'b001 << g);
      end else n_pass++;
      exp_q.push_back('{sel: g, data: {16'h0, d3[g]}});
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(e.sel) || out_data !== e.data[15:0]) begin
        $display("FAIL rr_word%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, out_valid, out_sel, out_data, e.sel, e.data[15:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_stall();
    int g;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (in_ready !== 3'b000) begin
        $display("FAIL stall_ready%0d: got %b expected 000", k, in_ready);
      end else n_pass++;
      @(posedge Clk); #1;
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 16'hC222) begin
        $display("FAIL stall_hold%0d: got v=%b sel=%0d data=%h expected v=1 sel=2 data=c222",
                 k, out_valid, out_sel, out_data);
      end else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      g = k;
      n_total++;
      if (in_ready !== (3'b001 << g)) begin
        $display("FAIL resume_ready%0d: got %b expected %b", k, in_ready, 3'b001 << g);
      end else n_pass++;
      exp_q.push_back('{sel: g, data: {16'h0, d3[g]}});
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(e.sel) || out_data !== e.data[15:0]) begin
        $display("FAIL resume_word%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, out_valid, out_sel, out_data, e.sel, e.data[15:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_single_channel();
    in_valid = 3'b100;
    in_data  = {16'h1234, 16'h0000, 16'h0000};
    #1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (in_ready !== 3'b100) begin
        $display("FAIL single_ready%0d: got %b expected 100", k, in_ready);
      end else n_pass++;
      exp_q.push_back('{sel: 2, data: 32'h1234});
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(e.sel) || out_data !== e.data[15:0]) begin
        $display("FAIL single_word%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, out_valid, out_sel, out_data, e.sel, e.data[15:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_transfer();
    n_total++;
    if (out_valid !== 1'b1) begin
      $display("FAIL midrst_pre: got v=%b expected v=1", out_valid);
    end else n_pass++;
    Reset_n = 1'b0;
    #2;
    n_total++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 16'h0 || in_ready !== 3'b000) begin
      $display("FAIL midrst_async: got v=%b sel=%0d data=%h rdy=%b expected v=0 sel=0 data=0000 rdy=000",
               out_valid, out_sel, out_data, in_ready);
    end else n_pass++;
    in_valid = 3'b111;
    in_data  = {d3[2], d3[1], d3[0]};
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 3'b001) begin
      $display("FAIL midrst_ready: got %b expected 001", in_ready);
    end else n_pass++;
    exp_q.push_back('{sel: 0, data: {16'h0, d3[0]}});
    @(posedge Clk); #1;
    e = exp_q.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || out_sel !== 2'(e.sel) || out_data !== e.data[15:0]) begin
      $display("FAIL midrst_word: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
               out_valid, out_sel, out_data, e.sel, e.data[15:0]);
    end else n_pass++;
  endtask

  task automatic test_wide();
    int g;
    for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = 32'hF000_0000 + i;
    in_valid8 = 8'hFF;
    #1;
    for (int k = 0; k < 10; k++) begin
      g = k % 8;
      n_total++;
      if (in_ready8 !== (8'h01 << g)) begin
        $display("FAIL wide_ready%0d: got %b expected %b", k, in_ready8, 8'h01 << g);
      end else n_pass++;
      exp_q.push_back('{sel: g, data: 32'hF000_0000 + g});
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if (out_valid8 !== 1'b1 || out_sel8 !== 3'(e.sel) || out_data8 !== e.data) begin
        $display("FAIL wide_word%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, out_valid8, out_sel8, out_data8, e.sel, e.data);
      end else n_pass++;
    end
    in_valid8 = '0;
  endtask

`ifdef RR_BUS_MUX_LOCK_EN
  task automatic test_lock();
    int grants [7] = '{0, 1, 1, 1, 1, 2, 0};
    logic locks [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    Reset_n  = 1'b0;
    in_valid = 3'b111;
    in_data  = {d3[2], d3[1], d3[0]};
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      lock = locks[k];
      #1;
      n_total++;
      if (in_ready !== (3'b001 << grants[k])) begin
        $display("FAIL lock_ready%0d: got %b expected %b", k, in_ready, 3'b001 << grants[k]);
      end else n_pass++;
      exp_q.push_back('{sel: grants[k], data: {16'h0, d3[grants[k]]}});
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(e.sel) || out_data !== e.data[15:0]) begin
        $display("FAIL lock_word%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, out_valid, out_sel, out_data, e.sel, e.data[15:0]);
      end else n_pass++;
    end
    lock = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_single_channel();
    test_reset_mid_transfer();
    test_wide();
`ifdef RR_BUS_MUX_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
